// File: rtl/tx_fifo_ctrl.sv
// Pointer/flag controller that turns a ram_2port into a synchronous FIFO.
// The RAM's read port is registered, so rd_valid trails an accepted pop by one cycle.
module tx_fifo_ctrl #(
    parameter int BusWidth  = 7,
    parameter int DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DataWidth-1:0] wr_data,
    output logic                 full,
    input  logic                 rd_en,
    output logic [DataWidth-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 empty,
    output logic [BusWidth:0]    count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clear_err,
    output logic                 ram_write,
    output logic [BusWidth-1:0]  ram_write_address,
    output logic [BusWidth-1:0]  ram_read_address,
    output logic [DataWidth-1:0] ram_data_in,
    input  logic [DataWidth-1:0] ram_data_out
);

    localparam logic [BusWidth:0] Depth = {1'b1, {BusWidth{1'b0}}};
    localparam logic [BusWidth:0] One   = {{BusWidth{1'b0}}, 1'b1};

    logic [BusWidth:0] r_wr_ptr;
    logic [BusWidth:0] r_rd_ptr;
    logic [BusWidth:0] r_count;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == Depth);
    assign w_push  = wr_en & ~w_full;
    assign w_pop   = rd_en & ~w_empty;

    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign rd_valid  = r_rd_valid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign rd_data   = ram_data_out;

    assign ram_write         = w_push;
    assign ram_write_address = r_wr_ptr[BusWidth-1:0];
    assign ram_read_address  = r_rd_ptr[BusWidth-1:0];
    assign ram_data_in       = wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + One;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + One;
        end
    end

    // Count, not the pointers, is the authority for full/empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + One;
                2'b01:   r_count <= r_count - One;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
        end
    end

    // Error flags are sticky; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en & w_full)
                r_overflow <= 1'b1;
            else if (clear_err)
                r_overflow <= 1'b0;
            if (rd_en & w_empty)
                r_underflow <= 1'b1;
            else if (clear_err)
                r_underflow <= 1'b0;
        end
    end

endmodule
